// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote at mid-bit.
// Latency: rx_done about 3 + 153*DIV clk after the rx falling edge; no backpressure, pulses are not held.
module uart_rx #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic [2:0] baud_set,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam logic [15:0] DIV_9600   = 16'(CLK_HZ / (9600 * 16));
  localparam logic [15:0] DIV_19200  = 16'(CLK_HZ / (19200 * 16));
  localparam logic [15:0] DIV_38400  = 16'(CLK_HZ / (38400 * 16));
  localparam logic [15:0] DIV_57600  = 16'(CLK_HZ / (57600 * 16));
  localparam logic [15:0] DIV_115200 = 16'(CLK_HZ / (115200 * 16));

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic        rx_meta, rx_s, rx_s_d;
  logic        start_edge;
  logic [15:0] div_sel, div_lat, pre_cnt;
  logic        tick;
  logic [3:0]  tick_cnt;
  logic [4:0]  tick_idx;
  logic [1:0]  samp;
  logic        majority;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        start_frame, done_set, err_set;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = rx_s_d & ~rx_s;

  always_comb begin
    case (baud_set)
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      default: div_sel = DIV_9600;
    endcase
  end

  // tick_cnt holds ticks already completed in the current bit, so tick_idx is 1..16
  assign tick       = (state != IDLE) && (pre_cnt == div_lat - 16'd1);
  assign tick_idx   = {1'b0, tick_cnt} + 5'd1;
  assign majority   = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign uart_state = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    if (!rx_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state_nxt   = START;
            start_frame = 1'b1;
          end
        end
        START: begin
          if (tick && tick_idx == 5'd9 && majority) state_nxt = IDLE;
          else if (tick && tick_idx == 5'd16)       state_nxt = DATA;
        end
        DATA: begin
          if (tick && tick_idx == 5'd16 && bit_idx == 3'd7) state_nxt = STOP;
        end
        STOP: begin
          // leave at mid-stop so a back-to-back start edge is not missed
          if (tick && tick_idx == 5'd9) begin
            state_nxt = IDLE;
            done_set  = majority;
            err_set   = ~majority;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_byte <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      div_lat   <= DIV_9600;
      pre_cnt   <= 16'd0;
      tick_cnt  <= 4'd0;
      samp      <= 2'b00;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      rx_done   <= done_set;
      frame_err <= err_set;
      if (done_set) data_byte <= shift_reg;
      if (start_frame) begin
        div_lat  <= div_sel;
        pre_cnt  <= 16'd0;
        tick_cnt <= 4'd0;
        bit_idx  <= 3'd0;
      end else if (state != IDLE) begin
        if (tick) begin
          pre_cnt  <= 16'd0;
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_idx == 5'd7) samp[0] <= rx_s;
          if (tick_idx == 5'd8) samp[1] <= rx_s;
          if (state == DATA && tick_idx == 5'd9)  shift_reg[bit_idx] <= majority;
          if (state == DATA && tick_idx == 5'd16) bit_idx <= bit_idx + 3'd1;
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
      end
    end
  end

endmodule
